param_exec_datapath: RTL and testbench

Parametrised successor of the 16-bit execution datapath. It keeps the A/B bus structure around a register bank, the T1/T2/PC/AO/DO/DI/IRF/IRE registers and the ALU with flags. Width and register count are parameters, and buses drive 0 rather than Z when unselected. It adds a valid/ready control-step handshake and a req/ack memory interface with wait-state stalling. It sits between the microsequencer (which supplies control words) and the memory subsystem.

---
 rtl/exec_pkg.sv | 79 +++++++
 rtl/param_alu.sv | 65 ++++++
 rtl/param_exec_datapath.sv | 171 +++++++++++++++++
 tb/tb_param_exec_datapath.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared definitions for the parametrised execution datapath: control-word
// layout, bus/destination/memory/ALU codes, flag bit positions, FSM states.
package exec_pkg;

    localparam int CTRL_W = 25;

    // Control-word field positions, MSB first
    localparam int SRCA_HI  = 24;
    localparam int SRCA_LO  = 22;
    localparam int SRCB_HI  = 21;
    localparam int SRCB_LO  = 19;
    localparam int DSTRX_HI = 18;
    localparam int DSTRX_LO = 17;
    localparam int DSTRY_HI = 16;
    localparam int DSTRY_LO = 15;
    localparam int DSTT2_HI = 14;
    localparam int DSTT2_LO = 13;
    localparam int DSTPC_HI = 12;
    localparam int DSTPC_LO = 11;
    localparam int DSTAO_HI = 10;
    localparam int DSTAO_LO = 9;
    localparam int MEMOP_HI = 8;
    localparam int MEMOP_LO = 7;
    localparam int ALUOP_HI = 6;
    localparam int ALUOP_LO = 3;
    localparam int FLAGUPD  = 2;
    localparam int T1UPD    = 1;
    localparam int IRELOAD  = 0;

    // Bus source codes; DI is only reachable from the B bus
    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_RX   = 3'd1,
        SRC_RY   = 3'd2,
        SRC_T1   = 3'd3,
        SRC_T2   = 3'd4,
        SRC_PC   = 3'd5,
        SRC_DI   = 3'd6
    } busSrcT;

    // Destination load codes; code 3 behaves as hold
    typedef enum logic [1:0] {
        DST_HOLD = 2'd0,
        DST_BUSA = 2'd1,
        DST_BUSB = 2'd2
    } dstT;

    typedef enum logic [1:0] {
        MEM_NONE   = 2'd0,
        MEM_RD_DI  = 2'd1,
        MEM_RD_IRF = 2'd2,
        MEM_WR     = 2'd3
    } memOpT;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_NOT   = 4'd5,
        ALU_SHL   = 4'd6,
        ALU_SHR   = 4'd7,
        ALU_PASSB = 4'd8,
        ALU_INC   = 4'd9
    } aluOpT;

    // Flag register layout {Z,N,C,V}
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MEM_WAIT = 1'b1
    } stateT;

endpackage

// File: rtl/param_alu.sv
// Combinational ALU; arithmetic is done one bit wider than the data so the
// carry/borrow falls out of the top bit. Returns result and flag candidates.
module param_alu
    import exec_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] opA,
    input  logic [DATA_W-1:0] opB,
    input  logic [3:0]        aluOp,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        flags
);

    localparam int MSB = DATA_W - 1;

    logic [DATA_W:0] wide;
    logic            carry;
    logic            ovf;

    // Operation select plus per-op carry and signed-overflow rules
    always_comb begin
        wide  = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (aluOp)
            ALU_ADD: begin
                wide  = {1'b0, opA} + {1'b0, opB};
                carry = wide[DATA_W];
                ovf   = (opA[MSB] == opB[MSB]) && (wide[MSB] != opA[MSB]);
            end
            ALU_SUB: begin
                wide  = {1'b0, opA} - {1'b0, opB};
                carry = ~wide[DATA_W];
                ovf   = (opA[MSB] != opB[MSB]) && (wide[MSB] != opA[MSB]);
            end
            ALU_AND:   wide = {1'b0, opA & opB};
            ALU_OR:    wide = {1'b0, opA | opB};
            ALU_XOR:   wide = {1'b0, opA ^ opB};
            ALU_NOT:   wide = {1'b0, ~opA};
            ALU_SHL: begin
                wide  = {opA, 1'b0};
                carry = opA[MSB];
            end
            ALU_SHR: begin
                wide  = {2'b00, opA[MSB:1]};
                carry = opA[0];
            end
            ALU_PASSB: wide = {1'b0, opB};
            ALU_INC: begin
                wide  = {1'b0, opA} + {{DATA_W{1'b0}}, 1'b1};
                carry = wide[DATA_W];
                ovf   = ~opA[MSB] & wide[MSB];
            end
            default:   wide = '0;
        endcase
        result         = wide[MSB:0];
        flags          = '0;
        flags[FLAG_Z]  = (wide[MSB:0] == '0);
        flags[FLAG_N]  = wide[MSB];
        flags[FLAG_C]  = carry;
        flags[FLAG_V]  = ovf;
    end

endmodule

// File: rtl/param_exec_datapath.sv
// Parametrised execution datapath: register bank and temporaries on an A/B
// bus pair, ALU with flag register, and a stalling req/ack memory port.
//
// Handshake: a control step is taken on a rising edge where CtrlValid and
// CtrlReady are both high; the sequencer holds CtrlWord until then. A memory
// request stays up (address/data stable) until the edge where MemAck is high.
module param_exec_datapath
    import exec_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int NUM_REGS = 8
) (
    input  logic                        ClockInput,
    input  logic                        ResetN,
    input  logic                        CtrlValid,
    output logic                        CtrlReady,
    input  logic [CTRL_W-1:0]           CtrlWord,
    input  logic [$clog2(NUM_REGS)-1:0] RxSel,
    input  logic [$clog2(NUM_REGS)-1:0] RySel,
    output logic                        MemReq,
    output logic                        MemWe,
    output logic [ADDR_W-1:0]           MemAddr,
    output logic [DATA_W-1:0]           MemWData,
    input  logic [DATA_W-1:0]           MemRData,
    input  logic                        MemAck,
    output logic [3:0]                  AluFlag,
    output logic [DATA_W-1:0]           IreRead
);

    logic [DATA_W-1:0] regBank [NUM_REGS];
    logic [DATA_W-1:0] t1, t2, pc, doReg, di, irf, ire;
    logic [ADDR_W-1:0] ao;
    logic [3:0]        flagReg;
    stateT             state;
    logic              memReq, memWe;
    logic [1:0]        pendOp;

    logic [DATA_W-1:0] busA, busB, rxVal, ryVal, aluRes;
    logic [3:0]        aluFlags;
    logic              accept;
    logic [1:0]        dstRx, dstRy, dstT2, dstPc, dstAo, memOp;

    function automatic logic isLoad(input logic [1:0] dst);
        return (dst == DST_BUSA) || (dst == DST_BUSB);
    endfunction

    function automatic logic [DATA_W-1:0] pickBus(input logic [1:0] dst,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        return (dst == DST_BUSB) ? b : a;
    endfunction

    assign dstRx  = CtrlWord[DSTRX_HI:DSTRX_LO];
    assign dstRy  = CtrlWord[DSTRY_HI:DSTRY_LO];
    assign dstT2  = CtrlWord[DSTT2_HI:DSTT2_LO];
    assign dstPc  = CtrlWord[DSTPC_HI:DSTPC_LO];
    assign dstAo  = CtrlWord[DSTAO_HI:DSTAO_LO];
    assign memOp  = CtrlWord[MEMOP_HI:MEMOP_LO];
    assign rxVal  = regBank[RxSel];
    assign ryVal  = regBank[RySel];

    assign CtrlReady = (state == ST_IDLE);
    assign accept    = CtrlValid && (state == ST_IDLE);
    assign MemReq    = memReq;
    assign MemWe     = memWe;
    assign MemAddr   = ao;
    assign MemWData  = doReg;
    assign AluFlag   = flagReg;
    assign IreRead   = ire;

    // A bus source mux; unselected codes drive zero
    always_comb begin
        busA = '0;
        case (CtrlWord[SRCA_HI:SRCA_LO])
            SRC_RX:  busA = rxVal;
            SRC_RY:  busA = ryVal;
            SRC_T1:  busA = t1;
            SRC_T2:  busA = t2;
            SRC_PC:  busA = pc;
            default: busA = '0;
        endcase
    end

    // B bus source mux; the only path out of DI
    always_comb begin
        busB = '0;
        case (CtrlWord[SRCB_HI:SRCB_LO])
            SRC_RX:  busB = rxVal;
            SRC_RY:  busB = ryVal;
            SRC_T1:  busB = t1;
            SRC_T2:  busB = t2;
            SRC_PC:  busB = pc;
            SRC_DI:  busB = di;
            default: busB = '0;
        endcase
    end

    param_alu #(.DATA_W(DATA_W)) uAlu (
        .opA    (busA),
        .opB    (busB),
        .aluOp  (CtrlWord[ALUOP_HI:ALUOP_LO]),
        .result (aluRes),
        .flags  (aluFlags)
    );

    // Register bank writes; Ry is written last so it wins on an index clash
    always_ff @(posedge ClockInput or negedge ResetN) begin
        if (!ResetN) begin
            for (int i = 0; i < NUM_REGS; i++) regBank[i] <= '0;
        end else if (accept) begin
            if (isLoad(dstRx)) regBank[RxSel] <= pickBus(dstRx, busA, busB);
            if (isLoad(dstRy)) regBank[RySel] <= pickBus(dstRy, busA, busB);
        end
    end

    // Temporaries, PC, AO, DO, flags and IRE all update on the accepting edge
    always_ff @(posedge ClockInput or negedge ResetN) begin
        if (!ResetN) begin
            t1      <= '0;
            t2      <= '0;
            pc      <= '0;
            ao      <= '0;
            doReg   <= '0;
            ire     <= '0;
            flagReg <= '0;
        end else if (accept) begin
            if (isLoad(dstT2))          t2      <= pickBus(dstT2, busA, busB);
            if (isLoad(dstPc))          pc      <= pickBus(dstPc, busA, busB);
            if (isLoad(dstAo))          ao      <= ADDR_W'(pickBus(dstAo, busA, busB));
            if (CtrlWord[T1UPD])        t1      <= aluRes;
            if (CtrlWord[FLAGUPD])      flagReg <= aluFlags;
            if (CtrlWord[IRELOAD])      ire     <= irf;
            if (memOp == MEM_WR)        doReg   <= busA;
        end
    end

    // Memory FSM: request raised after accept, dropped on ack; reads land here
    always_ff @(posedge ClockInput or negedge ResetN) begin
        if (!ResetN) begin
            state  <= ST_IDLE;
            memReq <= 1'b0;
            memWe  <= 1'b0;
            pendOp <= MEM_NONE;
            di     <= '0;
            irf    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept && (memOp != MEM_NONE)) begin
                        state  <= ST_MEM_WAIT;
                        memReq <= 1'b1;
                        memWe  <= (memOp == MEM_WR);
                        pendOp <= memOp;
                    end
                end
                ST_MEM_WAIT: begin
                    if (MemAck) begin
                        if (pendOp == MEM_RD_DI)  di  <= MemRData;
                        if (pendOp == MEM_RD_IRF) irf <= MemRData;
                        memReq <= 1'b0;
                        memWe  <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_param_exec_datapath.sv
// Directed bench for param_exec_datapath. Register contents are observed by
// writing them to memory; a monitor checks each memory request against the
// expected transaction queue.
module tb_param_exec_datapath;
    import exec_pkg::*;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        ctrlValid = 1'b0;
    logic        ctrlReady;
    logic [24:0] ctrlWord = '0;
    logic [2:0]  rxSel = '0;
    logic [2:0]  rySel = '0;
    logic        memReq, memWe;
    logic [15:0] memAddr, memWData;
    logic [15:0] memRData = '0;
    logic        memAck = 1'b0;
    logic [3:0]  aluFlag;
    logic [15:0] ireRead;

    int          nChecks = 0;
    int          nFail = 0;
    // {we, addr, wdata}
    logic [32:0] exp_q[$];
    logic [15:0] aoExp = '0;

    logic        monPrev = 1'b0;
    logic [32:0] monExp;
    logic [15:0] heldAddr, heldData;

    always #5 clk = ~clk;

    param_exec_datapath #(.DATA_W(16), .ADDR_W(16), .NUM_REGS(8)) dut (
        .ClockInput (clk),
        .ResetN     (rstN),
        .CtrlValid  (ctrlValid),
        .CtrlReady  (ctrlReady),
        .CtrlWord   (ctrlWord),
        .RxSel      (rxSel),
        .RySel      (rySel),
        .MemReq     (memReq),
        .MemWe      (memWe),
        .MemAddr    (memAddr),
        .MemWData   (memWData),
        .MemRData   (memRData),
        .MemAck     (memAck),
        .AluFlag    (aluFlag),
        .IreRead    (ireRead)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        nChecks++;
        if (act !== expv) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic logic [24:0] mk(input int sa, input int sb, input int drx, input int dry,
                                       input int dt2, input int dpc, input int dao, input int mop,
                                       input int aop, input int fu, input int t1u, input int irl);
        logic [24:0] w;
        w        = '0;
        w[24:22] = sa[2:0];
        w[21:19] = sb[2:0];
        w[18:17] = drx[1:0];
        w[16:15] = dry[1:0];
        w[14:13] = dt2[1:0];
        w[12:11] = dpc[1:0];
        w[10:9]  = dao[1:0];
        w[8:7]   = mop[1:0];
        w[6:3]   = aop[3:0];
        w[2]     = fu[0];
        w[1]     = t1u[0];
        w[0]     = irl[0];
        return w;
    endfunction

    // Present one step and hold it until the accepting edge
    task automatic step(input logic [24:0] w, input logic [2:0] rx, input logic [2:0] ry);
        int n;
        n = 0;
        @(negedge clk);
        while (!ctrlReady && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ctrlReady) begin
            nChecks++;
            nFail++;
            $display("FAIL step_ready_timeout: CtrlReady=%0b after %0d cycles, expected 1", ctrlReady, n);
            return;
        end
        ctrlWord  = w;
        rxSel     = rx;
        rySel     = ry;
        ctrlValid = 1'b1;
        @(posedge clk);
        #1 ctrlValid = 1'b0;
    endtask

    // Answer the pending request after a number of wait cycles
    task automatic memServe(input int waits, input logic [15:0] rdata, input int expCycles, input string tag);
        int n;
        int reqCyc;
        logic readySeen;
        n = 0;
        reqCyc = 0;
        readySeen = 1'b0;
        @(negedge clk);
        while (!memReq && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!memReq) begin
            nChecks++;
            nFail++;
            $display("FAIL %s_req_timeout: MemReq=%0b, expected 1", tag, memReq);
            return;
        end
        for (int i = 0; i < waits; i++) begin
            reqCyc += int'(memReq);
            readySeen |= ctrlReady;
            @(negedge clk);
        end
        reqCyc += int'(memReq);
        readySeen |= ctrlReady;
        memRData = rdata;
        memAck   = 1'b1;
        @(posedge clk);
        #1 memAck = 1'b0;
        @(negedge clk);
        check({tag, "_req_cycles"}, reqCyc, expCycles);
        check({tag, "_ready_low"}, {31'd0, readySeen}, 0);
        check({tag, "_req_drop"}, {31'd0, memReq}, 0);
        check({tag, "_ready_back"}, {31'd0, ctrlReady}, 1);
    endtask

    // Expose a bus-A source by writing it to memory at the current AO
    task automatic readOut(input int sa, input logic [2:0] rx, input logic [2:0] ry,
                           input logic [15:0] val, input string tag);
        exp_q.push_back({1'b1, aoExp, val});
        step(mk(sa, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0), rx, ry);
        memServe(0, 16'h0000, 1, tag);
    endtask

    // Fetch a value into DI with a read, then move it into bank entry idx
    task automatic loadReg(input logic [2:0] idx, input logic [15:0] val);
        exp_q.push_back({1'b0, aoExp, 16'h0000});
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), 3'd0, 3'd0);
        memServe(0, val, 1, "ld");
        step(mk(0, 6, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0), idx, 3'd0);
    endtask

    // Monitor: compare each new request to the queue and check it stays stable
    initial begin
        forever begin
            @(negedge clk);
            if (memReq && !monPrev) begin
                if (exp_q.size() == 0) begin
                    nChecks++;
                    nFail++;
                    $display("FAIL mon_unexpected_req: addr 0x%0h we %0b, nothing expected", memAddr, memWe);
                end else begin
                    monExp = exp_q.pop_front();
                    check("mon_we", {31'd0, memWe}, {31'd0, monExp[32]});
                    check("mon_addr", {16'd0, memAddr}, {16'd0, monExp[31:16]});
                    if (monExp[32]) check("mon_wdata", {16'd0, memWData}, {16'd0, monExp[15:0]});
                end
                heldAddr = memAddr;
                heldData = memWData;
            end else if (memReq && monPrev) begin
                check("mon_addr_hold", {16'd0, memAddr}, {16'd0, heldAddr});
                check("mon_wdata_hold", {16'd0, memWData}, {16'd0, heldData});
            end
            monPrev = memReq;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'd0, ctrlReady}, 1);
        check("rst_memreq", {31'd0, memReq}, 0);
        check("rst_flags", {28'd0, aluFlag}, 0);
        check("rst_ire", {16'd0, ireRead}, 0);
        check("rst_addr", {16'd0, memAddr}, 0);
        check("rst_wdata", {16'd0, memWData}, 0);

        // T1 = PC + 1, then PC = T1; flags untouched
        step(mk(5, 0, 0, 0, 0, 0, 0, 0, 9, 0, 1, 0), 3'd0, 3'd0);
        step(mk(3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 3'd0, 3'd0);
        @(negedge clk);
        check("pc_step_flags", {28'd0, aluFlag}, 0);
        readOut(5, 3'd0, 3'd0, 16'h0001, "pc_val");

        // ADD overflow, SUB to zero, XOR clears C/V
        loadReg(3'd1, 16'h7FFF);
        loadReg(3'd2, 16'h0001);
        step(mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), 3'd1, 3'd2);
        @(negedge clk);
        check("add_flags", {28'd0, aluFlag}, 32'b0101);
        readOut(3, 3'd0, 3'd0, 16'h8000, "add_t1");
        step(mk(1, 2, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0), 3'd2, 3'd2);
        @(negedge clk);
        check("sub_flags", {28'd0, aluFlag}, 32'b1010);
        step(mk(1, 2, 0, 0, 0, 0, 0, 0, 4, 1, 1, 0), 3'd1, 3'd2);
        @(negedge clk);
        check("xor_flags", {28'd0, aluFlag}, 32'b0000);
        readOut(3, 3'd0, 3'd0, 16'h7FFE, "xor_t1");

        // Read with 3 wait states at an address loaded in the same step
        loadReg(3'd3, 16'h0040);
        aoExp = 16'h0040;
        exp_q.push_back({1'b0, 16'h0040, 16'h0000});
        step(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0), 3'd3, 3'd0);
        memServe(3, 16'hBEEF, 4, "wait_rd");
        step(mk(0, 6, 0, 0, 0, 0, 0, 0, 8, 0, 1, 0), 3'd0, 3'd0);
        readOut(3, 3'd0, 3'd0, 16'hBEEF, "di_readback");

        // Write Ry to the address carried on B, acked in the first request cycle
        loadReg(3'd4, 16'h1234);
        loadReg(3'd5, 16'h0010);
        aoExp = 16'h0010;
        exp_q.push_back({1'b1, 16'h0010, 16'h1234});
        step(mk(2, 1, 0, 0, 0, 0, 2, 3, 0, 0, 0, 0), 3'd5, 3'd4);
        memServe(0, 16'h0000, 1, "wr");

        // Instruction fetch into IRF, then IRE load
        exp_q.push_back({1'b0, 16'h0010, 16'h0000});
        step(mk(0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0), 3'd0, 3'd0);
        memServe(1, 16'hA5A5, 2, "irf_rd");
        check("ire_before_load", {16'd0, ireRead}, 0);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 3'd0, 3'd0);
        @(negedge clk);
        check("ire_load", {16'd0, ireRead}, 32'h0000A5A5);

        // Rx and Ry on the same index: T1 (0xBEEF) on A, DI (0x0010) on B
        step(mk(3, 6, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0), 3'd6, 3'd6);
        readOut(1, 3'd6, 3'd0, 16'h0010, "same_idx");
        step(mk(3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 3'd0, 3'd0);
        readOut(4, 3'd0, 3'd0, 16'hBEEF, "t2_load");
        loadReg(3'd0, 16'h5A5A);
        readOut(1, 3'd0, 3'd0, 16'h5A5A, "r0_write");

        // Reset in the middle of a read
        exp_q.push_back({1'b0, aoExp, 16'h0000});
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), 3'd0, 3'd0);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_req", {31'd0, memReq}, 1);
        #2 rstN = 1'b0;
        #1;
        check("rst_async_req", {31'd0, memReq}, 0);
        check("rst_async_ready", {31'd0, ctrlReady}, 1);
        @(negedge clk);
        rstN  = 1'b1;
        aoExp = 16'h0000;
        memRData = 16'hDEAD;
        memAck   = 1'b1;
        @(negedge clk);
        memAck   = 1'b0;
        check("stray_ack_req", {31'd0, memReq}, 0);
        check("stray_ack_ready", {31'd0, ctrlReady}, 1);
        check("post_rst_flags", {28'd0, aluFlag}, 0);
        check("post_rst_ire", {16'd0, ireRead}, 0);
        step(mk(0, 6, 0, 0, 0, 0, 0, 0, 8, 0, 1, 0), 3'd0, 3'd0);
        readOut(3, 3'd0, 3'd0, 16'h0000, "di_after_rst");

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
